clint_avalon_responder: RTL and testbench



---
 rtl/clint_avalon_if.sv | 28 ++
 rtl/clint_avalon_responder.sv | 186 ++++++++++++++++++
 tb/tb_clint_avalon_responder.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/clint_avalon_if.sv
// Avalon-MM bus bundle between the core's dbus initiator and the CLINT.
//   avs_read/avs_write         : request strobes (initiator -> responder)
//   avs_address                : byte address, ADDR_W bits, bits [1:0] ignored
//   avs_writedata/byteenable   : write payload and byte lanes
//   avs_readdata/readdatavalid : read response (responder -> initiator)
//   avs_waitrequest            : back-pressure, tied low by the responder
interface clint_avalon_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              avs_read;
  logic              avs_write;
  logic [ADDR_W-1:0] avs_address;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic [31:0]       avs_readdata;
  logic              avs_readdatavalid;
  logic              avs_waitrequest;

  modport master (
    output avs_read, avs_write, avs_address, avs_writedata, avs_byteenable,
    input  avs_readdata, avs_readdatavalid, avs_waitrequest
  );

  modport slave (
    input  avs_read, avs_write, avs_address, avs_writedata, avs_byteenable,
    output avs_readdata, avs_readdatavalid, avs_waitrequest
  );
endinterface

// File: rtl/clint_avalon_responder.sv
// Core-local interruptor: 64-bit mtime/mtimecmp timer plus msip, exposed as an
// Avalon-MM responder with fixed one-cycle read latency and no wait states.
//   clk, rst           : core clock, asynchronous active-high reset
//   bus (slave)        : Avalon-MM responder port, see clint_avalon_if
//   software_interrupt : msip[0]
//   timer_interrupt    : registered (mtime >= mtimecmp)
// Optional feature: define CLINT_MTIME_SNAPSHOT_EN to latch mtime[63:32] when
// mtime low is read, so a low-then-high read sequence is tear-free.
module clint_avalon_responder #(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic           clk,
  input  logic           rst,
  clint_avalon_if.slave  bus,
  output logic           software_interrupt,
  output logic           timer_interrupt
);

  localparam int unsigned PRE_W  = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TIME_W = 64;

  localparam logic [15:0] OFF_MSIP      = 16'h0000;
  localparam logic [15:0] OFF_MTIMECMP0 = 16'h4000;
  localparam logic [15:0] OFF_MTIMECMP1 = 16'h4004;
  localparam logic [15:0] OFF_MTIME0    = 16'hBFF8;
  localparam logic [15:0] OFF_MTIME1    = 16'hBFFC;

  logic [TIME_W-1:0] mtime;
  logic [TIME_W-1:0] mtimecmp;
  logic              msip;
  logic [PRE_W-1:0]  prescaler;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  logic [TIME_W-1:0] mtime_nxt_c;
  logic [TIME_W-1:0] mtimecmp_nxt_c;
  logic              msip_nxt_c;
  logic [PRE_W-1:0]  prescaler_nxt_c;
  logic [DATA_W-1:0] rdata_c;
  logic              tick_c;

  // Word-aligned address and register decode
  logic [ADDR_W-1:0] addr_c;
  logic              hit_msip_c, hit_cmp_lo_c, hit_cmp_hi_c, hit_time_lo_c, hit_time_hi_c;
  logic              wr_c;
  logic              addr_unused;

  assign addr_c        = {bus.avs_address[ADDR_W-1:2], 2'b00};
  assign addr_unused   = ^bus.avs_address[1:0];
  assign hit_msip_c    = (addr_c == ADDR_W'(OFF_MSIP));
  assign hit_cmp_lo_c  = (addr_c == ADDR_W'(OFF_MTIMECMP0));
  assign hit_cmp_hi_c  = (addr_c == ADDR_W'(OFF_MTIMECMP1));
  assign hit_time_lo_c = (addr_c == ADDR_W'(OFF_MTIME0));
  assign hit_time_hi_c = (addr_c == ADDR_W'(OFF_MTIME1));

  // A write with no enabled lanes changes nothing anywhere
  assign wr_c = bus.avs_write && (bus.avs_byteenable != 4'b0000);

  // Lane-wise merge of write data into an existing word
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] wdata,
    input logic [3:0]        be
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

`ifdef CLINT_MTIME_SNAPSHOT_EN
  logic [DATA_W-1:0] snapshot;
  logic [DATA_W-1:0] snapshot_nxt_c;
`endif

  // Prescaler: mtime advances on the last count of each TICK_DIV window
  always_comb begin
    tick_c          = (prescaler == PRE_W'(TICK_DIV - 1));
    prescaler_nxt_c = tick_c ? '0 : prescaler + PRE_W'(1);
  end

  // Next-state for the architectural registers; software writes beat the tick
  always_comb begin
    mtime_nxt_c    = mtime;
    mtimecmp_nxt_c = mtimecmp;
    msip_nxt_c     = msip;

    if (wr_c && hit_time_lo_c) begin
      mtime_nxt_c[31:0] = merge_bytes(mtime[31:0], bus.avs_writedata, bus.avs_byteenable);
    end else if (wr_c && hit_time_hi_c) begin
      mtime_nxt_c[63:32] = merge_bytes(mtime[63:32], bus.avs_writedata, bus.avs_byteenable);
    end else if (tick_c) begin
      mtime_nxt_c = mtime + TIME_W'(1);
    end

    if (wr_c && hit_cmp_lo_c) begin
      mtimecmp_nxt_c[31:0] = merge_bytes(mtimecmp[31:0], bus.avs_writedata, bus.avs_byteenable);
    end
    if (wr_c && hit_cmp_hi_c) begin
      mtimecmp_nxt_c[63:32] = merge_bytes(mtimecmp[63:32], bus.avs_writedata, bus.avs_byteenable);
    end

    if (wr_c && hit_msip_c && bus.avs_byteenable[0]) begin
      msip_nxt_c = bus.avs_writedata[0];
    end
  end

`ifdef CLINT_MTIME_SNAPSHOT_EN
  // Snapshot follows the high word on a low-word read or a high-word write
  always_comb begin
    snapshot_nxt_c = snapshot;
    if (bus.avs_read && hit_time_lo_c) begin
      snapshot_nxt_c = mtime[63:32];
    end else if (wr_c && hit_time_hi_c) begin
      snapshot_nxt_c = merge_bytes(mtime[63:32], bus.avs_writedata, bus.avs_byteenable);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) snapshot <= '0;
    else     snapshot <= snapshot_nxt_c;
  end
`endif

  // Read mux sees pre-write register values; unmapped addresses read 0
  always_comb begin
    rdata_c = '0;
    if (hit_msip_c) begin
      rdata_c = {31'd0, msip};
    end else if (hit_cmp_lo_c) begin
      rdata_c = mtimecmp[31:0];
    end else if (hit_cmp_hi_c) begin
      rdata_c = mtimecmp[63:32];
    end else if (hit_time_lo_c) begin
      rdata_c = mtime[31:0];
    end else if (hit_time_hi_c) begin
`ifdef CLINT_MTIME_SNAPSHOT_EN
      rdata_c = snapshot;
`else
      rdata_c = mtime[63:32];
`endif
    end
  end

  // Timer state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      msip      <= 1'b0;
      prescaler <= '0;
    end else begin
      mtime     <= mtime_nxt_c;
      mtimecmp  <= mtimecmp_nxt_c;
      msip      <= msip_nxt_c;
      prescaler <= prescaler_nxt_c;
    end
  end

  // Read response: one-cycle latency, data held between responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= bus.avs_read;
      if (bus.avs_read) readdata <= rdata_c;
    end
  end

  // Interrupt compare uses this cycle's values, so it lags mtime by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer_interrupt <= 1'b0;
    else     timer_interrupt <= (mtime >= mtimecmp);
  end

  assign software_interrupt    = msip;
  assign bus.avs_readdata      = readdata;
  assign bus.avs_readdatavalid = readdatavalid;
  assign bus.avs_waitrequest   = 1'b0;

endmodule

// File: tb/tb_clint_avalon_responder.sv
module tb_clint_avalon_responder;

  localparam int unsigned TB_DIV = 1;

  logic clk;
  logic rst;
  logic si, ti, si4, ti4;

  int vectors;
  int miscompares;

  clint_avalon_if #(.ADDR_W(16)) bus  ();
  clint_avalon_if #(.ADDR_W(16)) bus4 ();

  clint_avalon_responder #(.TICK_DIV(TB_DIV), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .software_interrupt(si), .timer_interrupt(ti)
  );

  clint_avalon_responder #(.TICK_DIV(4), .ADDR_W(16)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4),
    .software_interrupt(si4), .timer_interrupt(ti4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip;
  logic [31:0] m_snap;
  longint unsigned m_cyc;
  logic        e_rdv, e_ti;
  logic [31:0] e_rd;

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] w,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? w[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [15:0] a);
    case (a)
      16'h0000: return {31'd0, m_msip};
      16'h4000: return m_cmp[31:0];
      16'h4004: return m_cmp[63:32];
      16'hBFF8: return m_mtime[31:0];
`ifdef CLINT_MTIME_SNAPSHOT_EN
      16'hBFFC: return m_snap;
`else
      16'hBFFC: return m_mtime[63:32];
`endif
      default:  return 32'd0;
    endcase
  endfunction

  logic [15:0] ma;
  logic        mtick;
  logic        mwr;
  assign ma    = {bus.avs_address[15:2], 2'b00};
  assign mtick = ((m_cyc % TB_DIV) == longint'(TB_DIV - 1));
  assign mwr   = bus.avs_write && (bus.avs_byteenable != 4'd0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mtime <= 64'd0;
      m_cmp   <= 64'hFFFF_FFFF_FFFF_FFFF;
      m_msip  <= 1'b0;
      m_snap  <= 32'd0;
      m_cyc   <= 0;
      e_rdv   <= 1'b0;
      e_rd    <= 32'd0;
      e_ti    <= 1'b0;
    end else begin
      m_cyc <= m_cyc + 1;
      e_ti  <= (m_mtime >= m_cmp);
      e_rdv <= bus.avs_read;
      if (bus.avs_read) e_rd <= m_read(ma);
      if (bus.avs_read && ma == 16'hBFF8) m_snap <= m_mtime[63:32];
      if (mwr && ma == 16'hBFF8)
        m_mtime <= {m_mtime[63:32], lanes(m_mtime[31:0], bus.avs_writedata, bus.avs_byteenable)};
      else if (mwr && ma == 16'hBFFC) begin
        m_mtime <= {lanes(m_mtime[63:32], bus.avs_writedata, bus.avs_byteenable), m_mtime[31:0]};
        m_snap  <= lanes(m_mtime[63:32], bus.avs_writedata, bus.avs_byteenable);
      end else if (mtick)
        m_mtime <= m_mtime + 64'd1;
      if (mwr && ma == 16'h4000)
        m_cmp[31:0] <= lanes(m_cmp[31:0], bus.avs_writedata, bus.avs_byteenable);
      if (mwr && ma == 16'h4004)
        m_cmp[63:32] <= lanes(m_cmp[63:32], bus.avs_writedata, bus.avs_byteenable);
      if (mwr && ma == 16'h0000 && bus.avs_byteenable[0])
        m_msip <= bus.avs_writedata[0];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("readdatavalid", 64'(bus.avs_readdatavalid), 64'(e_rdv));
      chk("readdata", 64'(bus.avs_readdata), 64'(e_rd));
      chk("timer_interrupt", 64'(ti), 64'(e_ti));
      chk("software_interrupt", 64'(si), 64'(m_msip));
      chk("waitrequest", 64'(bus.avs_waitrequest), 64'd0);
    end
  end

  // ---------------- directed stimulus (entered/left at a negedge) ----------------
  task automatic idle();
    bus.avs_read = 1'b0;
    bus.avs_write = 1'b0;
    bus.avs_byteenable = 4'h0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.avs_address = a;
    bus.avs_writedata = d;
    bus.avs_byteenable = be;
    bus.avs_write = 1'b1;
    @(negedge clk);
    idle();
  endtask

  task automatic rd_check(input string name, input logic [15:0] a, input logic [31:0] exp);
    bus.avs_address = a;
    bus.avs_read = 1'b1;
    @(negedge clk);
    chk({name, "_valid"}, 64'(bus.avs_readdatavalid), 64'd1);
    chk(name, 64'(bus.avs_readdata), 64'(exp));
    idle();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    idle();
    bus.avs_address = 16'h0;
    bus.avs_writedata = 32'h0;
    bus4.avs_read = 1'b0;
    bus4.avs_write = 1'b0;
    bus4.avs_address = 16'h0;
    bus4.avs_writedata = 32'h0;
    bus4.avs_byteenable = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset_readdatavalid", 64'(bus.avs_readdatavalid), 64'd0);
    chk("reset_readdata", 64'(bus.avs_readdata), 64'd0);
    rst = 1'b0;

    // Reset values
    rd_check("rd_cmp_hi_reset", 16'h4004, 32'hFFFF_FFFF);
    rd_check("rd_msip_reset", 16'h0000, 32'h0);
    chk("ti_after_reset", 64'(ti), 64'd0);
    chk("si_after_reset", 64'(si), 64'd0);

    // Software interrupt on/off
    wr(16'h0000, 32'h1, 4'hF);
    chk("si_set", 64'(si), 64'd1);
    rd_check("rd_msip_set", 16'h0000, 32'h1);
    wr(16'h0000, 32'h0, 4'hF);
    chk("si_clear", 64'(si), 64'd0);

    // Read and write together: read sees the old value, write lands
    bus.avs_address = 16'h0000;
    bus.avs_writedata = 32'h1;
    bus.avs_byteenable = 4'hF;
    bus.avs_write = 1'b1;
    bus.avs_read = 1'b1;
    @(negedge clk);
    chk("rw_same_old", 64'(bus.avs_readdata), 64'd0);
    chk("rw_same_si", 64'(si), 64'd1);
    idle();
    wr(16'h0000, 32'h0, 4'hF);
    wr(16'h0000, 32'h1, 4'h0);
    chk("be_zero_noop", 64'(si), 64'd0);
    wr(16'h0002, 32'hFFFF_FFFE, 4'h1);
    chk("msip_addr_lsb_ignored", 64'(si), 64'd0);

    // Carry and wrap across mtime words
    wr(16'hBFF8, 32'hFFFF_FFFE, 4'hF);
    wr(16'hBFFC, 32'h0, 4'hF);
    repeat (2) @(negedge clk);
`ifdef CLINT_MTIME_SNAPSHOT_EN
    rd_check("carry_lo", 16'hBFF8, 32'h0);
    rd_check("carry_hi", 16'hBFFC, 32'h1);
`else
    rd_check("carry_hi", 16'hBFFC, 32'h1);
    rd_check("carry_lo", 16'hBFF8, 32'h1);
`endif

    // Timer interrupt rise and fall
    wr(16'h4004, 32'h0, 4'hF);
    wr(16'h4000, 32'd100, 4'hF);
    wr(16'hBFFC, 32'h0, 4'hF);
    wr(16'hBFF8, 32'd95, 4'hF);
    repeat (5) @(negedge clk);
    chk("ti_before_100", 64'(ti), 64'd0);
    @(negedge clk);
    chk("ti_at_100", 64'(ti), 64'd1);
    wr(16'h4000, 32'hFFFF_FFFF, 4'hF);
    chk("ti_hold_one_cycle", 64'(ti), 64'd1);
    @(negedge clk);
    chk("ti_cleared", 64'(ti), 64'd0);

    // Byte lanes and unmapped address, back-to-back reads
    wr(16'h4000, 32'hAABB_CCDD, 4'b0010);
    rd_check("be_merge", 16'h4000, 32'hFFFF_CCFF);
    rd_check("unmapped", 16'h1234, 32'h0);
    wr(16'h1234, 32'h1, 4'hF);
    rd_check("unmapped_after_wr", 16'h1234, 32'h0);
    wr(16'h4007, 32'h1234_5678, 4'b1001);
    rd_check("cmp_hi_lanes", 16'h4004, 32'h1200_0078);

    // Prescaled instance: started with the same reset release, 4 cycles per tick
    repeat (10) @(negedge clk);
    bus4.avs_address = 16'hBFF8;
    bus4.avs_read = 1'b1;
    @(negedge clk);
    bus4.avs_read = 1'b0;
    chk("div4_valid", 64'(bus4.avs_readdatavalid), 64'd1);
    chk("div4_nonzero", 64'(bus4.avs_readdata != 32'd0), 64'd1);

    // Reset mid-response drops the pending valid
    bus.avs_address = 16'h4000;
    bus.avs_read = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_drops_valid", 64'(bus.avs_readdatavalid), 64'd0);
    idle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("no_resp_after_rst", 64'(bus.avs_readdatavalid), 64'd0);

    // Exact prescaler count: 40 edges after release at TICK_DIV=4 gives mtime 10
    repeat (40) @(negedge clk);
    bus4.avs_address = 16'hBFF8;
    bus4.avs_read = 1'b1;
    @(negedge clk);
    bus4.avs_read = 1'b0;
    chk("div4_valid_40", 64'(bus4.avs_readdatavalid), 64'd1);
    chk("div4_mtime_40", 64'(bus4.avs_readdata), 64'd10);
    chk("div4_ti", 64'(ti4), 64'd0);
    rd_check("rd_cmp_lo_reset", 16'h4000, 32'hFFFF_FFFF);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
